// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode/state enums and the status flag bundle.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } flags_t;

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative datapath, one bit per cycle over WIDTH cycles.
// Shift-add unsigned multiply; with div_mode set, unsigned restoring divide
// (only ever requested when SEQ_ALU_DIV_EN is defined in the core).
// {hi, lo} holds product (MUL) or {remainder, quotient} (DIV).
// done is high during the final step; res is then the finished value.
module seq_alu_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi, lo, m, hi_nx, lo_nx, rem_dif;
   logic [WIDTH:0]   add_sum, rem_sh;
   logic [CW-1:0]    cnt;
   logic             busy, div_q;

   // One iteration step: add-and-shift-right for MUL, shift-left-and-subtract for DIV.
   always_comb begin
      add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      rem_sh  = {hi, lo[WIDTH-1]};
      // Only used when rem_sh >= m, so the difference always fits in WIDTH bits.
      rem_dif = rem_sh[WIDTH-1:0] - m;
      if (div_q) begin
         if (rem_sh >= {1'b0, m}) begin
            hi_nx = rem_dif;
            lo_nx = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nx = rem_sh[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_nx = add_sum[WIDTH:1];
         lo_nx = {add_sum[0], lo[WIDTH-1:1]};
      end
   end

   // Load operands on start, then step WIDTH times counting WIDTH-1 down to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         div_q <= 1'b0;
      end else if (start) begin
         hi    <= '0;
         lo    <= div_mode ? a : b;
         m     <= div_mode ? b : a;
         cnt   <= CW'(WIDTH - 1);
         busy  <= 1'b1;
         div_q <= div_mode;
      end else if (busy) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
         cnt <= cnt - 1'b1;
         if (cnt == '0) busy <= 1'b0;
      end
   end

   assign done = busy && (cnt == '0);
   assign res  = {hi_nx, lo_nx};

endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: registered ALU with valid/ready in and out, accumulator
// operand mode, status flags and a multi-cycle multiplier.
// Optional macro SEQ_ALU_DIV_EN: use_acc=1 with op=111 selects unsigned divide.
module seq_alu_core
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic               use_acc,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_n,
   output logic               flag_v,
   output logic               err,
   output logic [WIDTH-1:0]   acc
);

   localparam int SHW = $clog2(WIDTH);

   state_e             state;
   logic [2*WIDTH-1:0] res_q, it_res;
   flags_t             flg_q;
   logic               err_q, div_q, dz_q, div_sel, it_done, iter_start;
   logic [WIDTH-1:0]   acc_q, a_op, sc_res;
   logic               sc_c, sc_v;
   logic [SHW-1:0]     sh;

   assign a_op = use_acc ? acc_q : a_in;
   assign sh   = b_in[SHW-1:0];

`ifdef SEQ_ALU_DIV_EN
   assign div_sel = use_acc;
`else
   assign div_sel = 1'b0;
`endif

   assign in_ready   = rst_n && (state == S_IDLE);
   assign iter_start = in_valid && in_ready && (op_e'(op) == OP_MUL);

   // Single-cycle ops evaluated straight from the presented operands.
   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            {sc_c, sc_res} = {1'b0, a_op} + {1'b0, b_in};
            sc_v = (a_op[WIDTH-1] == b_in[WIDTH-1]) && (sc_res[WIDTH-1] != a_op[WIDTH-1]);
         end
         OP_SUB: begin
            {sc_c, sc_res} = {1'b0, a_op} - {1'b0, b_in};
            sc_v = (a_op[WIDTH-1] != b_in[WIDTH-1]) && (sc_res[WIDTH-1] != a_op[WIDTH-1]);
         end
         OP_AND: sc_res = a_op & b_in;
         OP_OR:  sc_res = a_op | b_in;
         OP_XOR: sc_res = a_op ^ b_in;
         // Extra bit catches the last bit shifted out; zero for a shift of 0.
         OP_SHL: {sc_c, sc_res} = {1'b0, a_op} << sh;
         OP_SHR: {sc_res, sc_c} = {a_op, 1'b0} >> sh;
         default: ;
      endcase
   end

   seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (iter_start),
      .div_mode (div_sel),
      .a        (a_op),
      .b        (b_in),
      .done     (it_done),
      .res      (it_res)
   );

   // Control FSM: latch results/flags on entry to DONE, hold until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         res_q <= '0;
         flg_q <= '0;
         err_q <= 1'b0;
         acc_q <= '0;
         div_q <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               if (op_e'(op) == OP_MUL) begin
                  div_q <= div_sel;
                  dz_q  <= div_sel && (b_in == '0);
                  state <= S_EXEC;
               end else begin
                  res_q <= {{WIDTH{1'b0}}, sc_res};
                  flg_q <= '{z: (sc_res == '0), c: sc_c, n: sc_res[WIDTH-1], v: sc_v};
                  err_q <= 1'b0;
                  acc_q <= sc_res;
                  state <= S_DONE;
               end
            end
            S_EXEC: if (it_done) begin
               res_q <= it_res;
               // Divide flags look at the quotient only; multiply at the full product.
               flg_q <= '{z: (div_q ? (it_res[WIDTH-1:0] == '0) : (it_res == '0)),
                          c: 1'b0, n: it_res[WIDTH-1], v: 1'b0};
               err_q <= dz_q;
               if (!dz_q) acc_q <= it_res[WIDTH-1:0];
               state <= S_DONE;
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = (state == S_DONE);
   assign result    = res_q;
   assign flag_z    = flg_q.z;
   assign flag_c    = flg_q.c;
   assign flag_n    = flg_q.n;
   assign flag_v    = flg_q.v;
   assign err       = err_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: directed vector table plus hand sequences for hold,
// mid-operation reset and the divide/multiply alias of op 111.
module tb_seq_alu_core;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [2:0]     op = 3'd0;
   logic           use_acc = 1'b0;
   logic [W-1:0]   a_in = '0;
   logic [W-1:0]   b_in = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] result;
   logic           flag_z, flag_c, flag_n, flag_v, err;
   logic [W-1:0]   acc;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_alu_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .use_acc   (use_acc),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_n    (flag_n),
      .flag_v    (flag_v),
      .err       (err),
      .acc       (acc)
   );

   typedef struct {
      string       nm;
      logic [2:0]  op;
      logic        ua;
      logic [7:0]  a;
      logic [7:0]  b;
      int          hold;
      logic [15:0] res;
      logic [3:0]  zcnv;
      logic [7:0]  acc;
      logic        err;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one operation, measure latency, check outputs, optionally hold, then release.
   task automatic run(input vec_t v);
      int   lat, n;
      logic rdy_hi;
      op = v.op; use_acc = v.ua; a_in = v.a; b_in = v.b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      rdy_hi = in_ready;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         rdy_hi = rdy_hi | in_ready;
      end
      chk({v.nm, " latency"}, lat, v.lat);
      chk({v.nm, " result"}, result, v.res);
      chk({v.nm, " flags zcnv"}, {flag_z, flag_c, flag_n, flag_v}, v.zcnv);
      chk({v.nm, " acc"}, acc, v.acc);
      chk({v.nm, " err"}, err, v.err);
      chk({v.nm, " in_ready while busy"}, {rdy_hi, in_ready}, 2'b00);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         chk({v.nm, " hold"}, {out_valid, in_ready, flag_z, flag_c, flag_n, flag_v, result},
             {1'b1, 1'b0, v.zcnv, v.res});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({v.nm, " release"}, {out_valid, in_ready}, 2'b01);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      // name, op, use_acc, a, b, hold, result, zcnv, acc, err, latency
      tbl.push_back('{"add_carry",  3'd0, 1'b0, 8'd200, 8'd100, 0, 16'h002C, 4'b0100, 8'h2C, 1'b0, 1});
      tbl.push_back('{"sub_borrow", 3'd1, 1'b0, 8'd5,   8'd7,   0, 16'h00FE, 4'b0110, 8'hFE, 1'b0, 1});
      tbl.push_back('{"add_ovf",    3'd0, 1'b0, 8'h7F,  8'h01,  0, 16'h0080, 4'b0011, 8'h80, 1'b0, 1});
      tbl.push_back('{"and",        3'd2, 1'b0, 8'hF0,  8'h3C,  0, 16'h0030, 4'b0000, 8'h30, 1'b0, 1});
      tbl.push_back('{"or",         3'd3, 1'b0, 8'h0F,  8'hF0,  0, 16'h00FF, 4'b0010, 8'hFF, 1'b0, 1});
      tbl.push_back('{"xor_zero",   3'd4, 1'b0, 8'hAA,  8'hAA,  0, 16'h0000, 4'b1000, 8'h00, 1'b0, 1});
      tbl.push_back('{"shl1",       3'd5, 1'b0, 8'h81,  8'h01,  0, 16'h0002, 4'b0100, 8'h02, 1'b0, 1});
      tbl.push_back('{"shr1",       3'd6, 1'b0, 8'h81,  8'h01,  0, 16'h0040, 4'b0100, 8'h40, 1'b0, 1});
      tbl.push_back('{"shl0",       3'd5, 1'b0, 8'h5A,  8'h08,  0, 16'h005A, 4'b0000, 8'h5A, 1'b0, 1});
      tbl.push_back('{"shr0",       3'd6, 1'b0, 8'hDA,  8'h00,  0, 16'h00DA, 4'b0010, 8'hDA, 1'b0, 1});
      tbl.push_back('{"mul15x17",   3'd7, 1'b0, 8'd15,  8'd17,  0, 16'h00FF, 4'b0010, 8'hFF, 1'b0, 9});
      tbl.push_back('{"mul0",       3'd7, 1'b0, 8'h00,  8'h33,  0, 16'h0000, 4'b1000, 8'h00, 1'b0, 9});
      tbl.push_back('{"mul_max",    3'd7, 1'b0, 8'hFF,  8'hFF,  0, 16'hFE01, 4'b0000, 8'h01, 1'b0, 9});
      tbl.push_back('{"acc_add",    3'd0, 1'b0, 8'd3,   8'd4,   0, 16'h0007, 4'b0000, 8'h07, 1'b0, 1});
      tbl.push_back('{"acc_shl",    3'd5, 1'b1, 8'hEE,  8'd2,   5, 16'h001C, 4'b0000, 8'h1C, 1'b0, 1});
      tbl.push_back('{"acc_add2",   3'd0, 1'b1, 8'hEE,  8'h01,  0, 16'h001D, 4'b0000, 8'h1D, 1'b0, 1});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset outputs", {out_valid, in_ready, err, flag_z, flag_c, flag_n, flag_v, result, acc}, '0);
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", in_ready, 1'b1);

      foreach (tbl[i]) run(tbl[i]);

      // Reset in the middle of a multiply: aborted, acc cleared, no late result.
      op = 3'd7; use_acc = 1'b0; a_in = 8'd15; b_in = 8'd17; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mul busy before reset", {out_valid, in_ready}, 2'b00);
      rst_n = 1'b0;
      #1;
      chk("abort on reset", {out_valid, acc}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("in_ready after abort", in_ready, 1'b1);
      repeat (12) @(posedge clk);
      #1;
      chk("no result after abort", {out_valid, acc}, '0);
      run('{"add_after_rst", 3'd0, 1'b0, 8'd1, 8'd1, 0, 16'h0002, 4'b0000, 8'h02, 1'b0, 1});

      // op 111 with the accumulator operand
      run('{"load_acc100", 3'd0, 1'b0, 8'd100, 8'd0, 0, 16'h0064, 4'b0000, 8'h64, 1'b0, 1});
`ifdef SEQ_ALU_DIV_EN
      run('{"div100by7", 3'd7, 1'b1, 8'h00, 8'd7, 0, 16'h020E, 4'b0000, 8'h0E, 1'b0, 9});
      run('{"reload_acc", 3'd0, 1'b0, 8'd100, 8'd0, 0, 16'h0064, 4'b0000, 8'h64, 1'b0, 1});
      run('{"div_by_zero", 3'd7, 1'b1, 8'h00, 8'd0, 0, 16'h64FF, 4'b0010, 8'h64, 1'b1, 9});
`else
      run('{"acc_mul100x7", 3'd7, 1'b1, 8'h00, 8'd7, 0, 16'h02BC, 4'b0010, 8'hBC, 1'b0, 9});
      run('{"acc_mul_by0", 3'd7, 1'b1, 8'h00, 8'd0, 0, 16'h0000, 4'b1000, 8'h00, 1'b0, 9});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
